// File: rtl/ball_controller.sv
// ---------------------------------------------------------------------------
// ball_controller
//
// Frame-rate game sequencer for the ball-and-paddle display path. Each
// frame_tick while in PLAY advances the ball by SPEED pixels per axis,
// resolves wall / paddle / goal collisions for the mode latched at game
// start, and maintains both scores. Handles the serve pause, the post-point
// pause and the game-over hold.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   frame_tick        one-cycle pulse per video frame
//   start             one-cycle pulse, starts a game from IDLE or OVER
//   mode[1:0]         00 tennis, 01 football, 10 squash, 11 practice
//   bat_size          paddle half-height select: 1 = 35, 0 = 25
//   p1_y, p2_y        paddle centre rows
//   ball_x, ball_y    ball centre (box is [c-4, c+4) on each axis)
//   p1_score/p2_score scores
//   game_over         high while in OVER
//   playing           high while in PLAY
// ---------------------------------------------------------------------------
module ball_controller #(
    parameter int WIN_SCORE    = 11,  // <= 63
    parameter int SERVE_FRAMES = 60,
    parameter int SPEED        = 2    // 1..4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic        bat_size,
    input  logic [10:0] p1_y,
    input  logic [10:0] p2_y,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [5:0]  p1_score,
    output logic [5:0]  p2_score,
    output logic        game_over,
    output logic        playing
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_OVER
    } state_e;

    localparam logic [1:0] M_TENNIS = 2'b00;
    localparam logic [1:0] M_FOOT   = 2'b01;
    localparam logic [1:0] M_SQUASH = 2'b10;
    localparam logic [1:0] M_PRACT  = 2'b11;

    localparam int CW = $clog2(SERVE_FRAMES + 1);

    localparam logic [10:0] CX = 11'd320;
    localparam logic [10:0] CY = 11'd240;

    localparam logic signed [11:0] STEP = 12'(SPEED);

    // Paddle column left edges (each column is 10 pixels wide).
    localparam int L_P1  = 40;
    localparam int L_P1F = 480;
    localparam int L_P2  = 590;
    localparam int L_P2F = 150;
    localparam int L_P2S = 500;

    // Ball x after a paddle return: just clear of the paddle face on the
    // side the ball now travels toward.
    localparam logic signed [11:0] NX_P1     = 12'(L_P1 + 14);
    localparam logic signed [11:0] NX_P1F_L  = 12'(L_P1F + 14);
    localparam logic signed [11:0] NX_P2     = 12'(L_P2 - 4);
    localparam logic signed [11:0] NX_P2F    = 12'(L_P2F - 4);
    localparam logic signed [11:0] NX_P1F_R  = 12'(L_P1F - 4);
    localparam logic signed [11:0] NX_P2S    = 12'(L_P2S - 4);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [10:0]    x_q, x_d;
    logic [10:0]    y_q, y_d;
    logic           dx_pos_q, dx_pos_d;   // 1: moving +x
    logic           dy_pos_q, dy_pos_d;   // 1: moving +y
    logic [5:0]     p1_q, p1_d;
    logic [5:0]     p2_q, p2_d;
    logic           last_p2_q, last_p2_d; // squash: 1 when P2 hit last
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     mode_q, mode_d;
    logic           playing_q, over_q;

    // ---------------------------------------------------------------------
    // Ball physics for one PLAY frame
    // ---------------------------------------------------------------------
    logic signed [11:0] nx, ny;
    logic signed [12:0] bx, by, sz;
    logic               dy_n;
    logic               hit, hit_by_p2;
    logic signed [11:0] hit_nx;
    logic signed [11:0] edge_nx;
    logic               edge_dx;
    logic               in_mouth;
    logic               pt_p1, pt_p2, to_serve;
    logic signed [11:0] res_nx;
    logic               res_dx;

    // Ball box [bx-4, bx+4) overlaps paddle column [l, l+10) and the
    // ball row lies within the paddle span [py-sz, py+sz).
    function automatic logic pad_hit(input logic signed [12:0] cx,
                                     input logic signed [12:0] cy,
                                     input int                 l,
                                     input logic [10:0]        py,
                                     input logic signed [12:0] half);
        logic signed [12:0] lc;
        logic signed [12:0] pc;
        lc = 13'(l);
        pc = $signed({2'b00, py});
        pad_hit = (cx - 13'sd4 < lc + 13'sd10) && (cx + 13'sd4 > lc) &&
                  (cy >= pc - half) && (cy < pc + half);
    endfunction

    always_comb begin
        nx = $signed({1'b0, x_q}) + (dx_pos_q ? STEP : -STEP);
        ny = $signed({1'b0, y_q}) + (dy_pos_q ? STEP : -STEP);

        // Top / bottom walls
        dy_n = dy_pos_q;
        if (ny < 12'sd34) begin
            ny   = 12'sd34;
            dy_n = 1'b1;
        end else if (ny > 12'sd446) begin
            ny   = 12'sd446;
            dy_n = 1'b0;
        end

        bx = {nx[11], nx};
        by = {ny[11], ny};
        sz = bat_size ? 13'sd35 : 13'sd25;

        // Paddles. Within a mode the columns that reflect a given travel
        // direction never overlap, so grouping by direction keeps the
        // listed priority.
        hit       = 1'b0;
        hit_by_p2 = 1'b0;
        hit_nx    = nx;
        case (mode_q)
            M_TENNIS, M_FOOT: begin
                if (!dx_pos_q) begin
                    if (pad_hit(bx, by, L_P1, p1_y, sz)) begin
                        hit    = 1'b1;
                        hit_nx = NX_P1;
                    end else if (mode_q == M_FOOT &&
                                 pad_hit(bx, by, L_P1F, p1_y, sz)) begin
                        hit    = 1'b1;
                        hit_nx = NX_P1F_L;
                    end
                end else begin
                    if (pad_hit(bx, by, L_P2, p2_y, sz)) begin
                        hit       = 1'b1;
                        hit_by_p2 = 1'b1;
                        hit_nx    = NX_P2;
                    end else if (mode_q == M_FOOT &&
                                 pad_hit(bx, by, L_P2F, p2_y, sz)) begin
                        hit       = 1'b1;
                        hit_by_p2 = 1'b1;
                        hit_nx    = NX_P2F;
                    end
                end
            end
            default: begin
                // Squash / practice: both bats face the left wall.
                if (dx_pos_q) begin
                    if (pad_hit(bx, by, L_P1F, p1_y, sz)) begin
                        hit    = 1'b1;
                        hit_nx = NX_P1F_R;
                    end else if (pad_hit(bx, by, L_P2S, p2_y, sz)) begin
                        hit       = 1'b1;
                        hit_by_p2 = 1'b1;
                        hit_nx    = NX_P2S;
                    end
                end
            end
        endcase

        // Left / right edges; football goals only span rows [130, 350).
        in_mouth = (ny >= 12'sd130) && (ny < 12'sd350);
        edge_nx  = nx;
        edge_dx  = dx_pos_q;
        pt_p1    = 1'b0;
        pt_p2    = 1'b0;
        to_serve = 1'b0;
        if (!hit) begin
            if (nx < 12'sd24) begin
                if (mode_q[1] || (mode_q == M_FOOT && !in_mouth)) begin
                    edge_nx = 12'sd34;
                    edge_dx = 1'b1;
                end else begin
                    pt_p2 = 1'b1;
                end
            end else if (nx > 12'sd616) begin
                if (mode_q == M_FOOT && !in_mouth) begin
                    edge_nx = 12'sd606;
                    edge_dx = 1'b0;
                end else if (mode_q == M_PRACT) begin
                    to_serve = 1'b1;
                end else if (mode_q == M_SQUASH) begin
                    pt_p1 = last_p2_q;
                    pt_p2 = !last_p2_q;
                end else begin
                    pt_p1 = 1'b1;
                end
            end
        end

        res_nx = hit ? hit_nx : edge_nx;
        res_dx = hit ? !dx_pos_q : edge_dx;
    end

    // ---------------------------------------------------------------------
    // Sequencer next state
    // ---------------------------------------------------------------------
    logic [5:0] p1_inc, p2_inc;
    assign p1_inc = p1_q + 6'd1;
    assign p2_inc = p2_q + 6'd1;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_pos_d  = dx_pos_q;
        dy_pos_d  = dy_pos_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        last_p2_d = last_p2_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                // start outranks a coincident frame_tick here
                if (start) begin
                    state_d = S_SERVE;
                    p1_d    = '0;
                    p2_d    = '0;
                    mode_d  = mode;
                    x_d     = CX;
                    y_d     = CY;
                    cnt_d   = '0;
                end
            end

            S_SERVE, S_POINT: begin
                if (frame_tick) begin
                    if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
                        cnt_d   = '0;
                        state_d = S_PLAY;
                        if (state_q == S_POINT) begin
                            x_d = CX;
                            y_d = CY;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            S_PLAY: begin
                if (frame_tick) begin
                    x_d      = res_nx[10:0];
                    y_d      = ny[10:0];
                    dx_pos_d = res_dx;
                    dy_pos_d = dy_n;
                    if (hit && mode_q == M_SQUASH)
                        last_p2_d = hit_by_p2;

                    if (pt_p1 || pt_p2) begin
                        // Next serve heads toward the loser; P2 sits right.
                        dx_pos_d = pt_p1;
                        cnt_d    = '0;
                        if (pt_p1) p1_d = p1_inc;
                        else       p2_d = p2_inc;
                        if ((pt_p1 && p1_inc == 6'(WIN_SCORE)) ||
                            (pt_p2 && p2_inc == 6'(WIN_SCORE))) begin
                            state_d = S_OVER;
                            x_d     = CX;
                            y_d     = CY;
                        end else begin
                            state_d = S_POINT;
                        end
                    end else if (to_serve) begin
                        state_d = S_SERVE;
                        cnt_d   = '0;
                        x_d     = CX;
                        y_d     = CY;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= CX;
            y_q       <= CY;
            dx_pos_q  <= 1'b1;
            dy_pos_q  <= 1'b1;
            p1_q      <= '0;
            p2_q      <= '0;
            last_p2_q <= 1'b0;
            cnt_q     <= '0;
            mode_q    <= M_TENNIS;
            playing_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_pos_q  <= dx_pos_d;
            dy_pos_q  <= dy_pos_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            last_p2_q <= last_p2_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            playing_q <= (state_d == S_PLAY);
            over_q    <= (state_d == S_OVER);
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign p1_score  = p1_q;
    assign p2_score  = p2_q;
    assign game_over = over_q;
    assign playing   = playing_q;

endmodule

// File: tb/tb_ball_controller.sv
// ---------------------------------------------------------------------------
// tb_ball_controller
//
// Directed table of hand-derived tennis vectors, hand-written multi-cycle
// corner sequences (async reset, full game to OVER, restart), and per-mode
// randomized runs scored against a behavioural game model.
// ---------------------------------------------------------------------------
module tb_ball_controller;

    localparam int SERVE_N = 60;
    localparam int WIN_N   = 11;
    localparam int SPD_N   = 2;

    localparam int MS_IDLE  = 0;
    localparam int MS_SERVE = 1;
    localparam int MS_PLAY  = 2;
    localparam int MS_POINT = 3;
    localparam int MS_OVER  = 4;

    logic        clk, rst, frame_tick, start, bat_size;
    logic [1:0]  mode;
    logic [10:0] p1_y, p2_y, ball_x, ball_y;
    logic [5:0]  p1_score, p2_score;
    logic        game_over, playing;

    ball_controller #(.WIN_SCORE(WIN_N), .SERVE_FRAMES(SERVE_N), .SPEED(SPD_N)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .mode(mode), .bat_size(bat_size), .p1_y(p1_y), .p2_y(p2_y),
        .ball_x(ball_x), .ball_y(ball_y), .p1_score(p1_score),
        .p2_score(p2_score), .game_over(game_over), .playing(playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- behavioural game model ----------------
    int m_st, m_x, m_y, m_dx, m_dy, m_p1, m_p2, m_last, m_cnt, m_mode;

    task automatic model_reset();
        m_st = MS_IDLE; m_x = 320; m_y = 240; m_dx = 1; m_dy = 1;
        m_p1 = 0; m_p2 = 0; m_last = 1; m_cnt = 0; m_mode = 0;
    endtask

    task automatic model_step(input bit st, input bit tk, input int md,
                              input bit bs, input int py1, input int py2);
        int nx, ny, sz, win, np, py;
        int pl[4];
        int pown[4];
        int pdir[4];
        bit hit, mouth;
        if (m_st == MS_IDLE || m_st == MS_OVER) begin
            if (st) begin
                m_p1 = 0; m_p2 = 0; m_mode = md; m_x = 320; m_y = 240;
                m_cnt = 0; m_st = MS_SERVE;
            end
            return;
        end
        if (!tk) return;
        if (m_st == MS_SERVE || m_st == MS_POINT) begin
            m_cnt++;
            if (m_cnt == SERVE_N) begin
                m_cnt = 0;
                if (m_st == MS_POINT) begin m_x = 320; m_y = 240; end
                m_st = MS_PLAY;
            end
            return;
        end
        nx = m_x + m_dx * SPD_N;
        ny = m_y + m_dy * SPD_N;
        if (ny < 34) begin ny = 34; m_dy = 1; end
        else if (ny > 446) begin ny = 446; m_dy = -1; end
        sz = bs ? 35 : 25;
        case (m_mode)
            0: begin np = 2; pl = '{40, 590, 0, 0}; pown = '{1, 2, 0, 0}; pdir = '{-1, 1, 0, 0}; end
            1: begin np = 4; pl = '{40, 480, 590, 150}; pown = '{1, 1, 2, 2}; pdir = '{-1, -1, 1, 1}; end
            default: begin np = 2; pl = '{480, 500, 0, 0}; pown = '{1, 2, 0, 0}; pdir = '{1, 1, 0, 0}; end
        endcase
        hit = 0;
        for (int i = 0; i < np; i++) begin
            if (!hit) begin
                py = (pown[i] == 1) ? py1 : py2;
                if (m_dx == pdir[i] && nx + 4 > pl[i] && nx - 4 < pl[i] + 10 &&
                    ny >= py - sz && ny < py + sz) begin
                    hit = 1;
                    nx = (pdir[i] < 0) ? pl[i] + 14 : pl[i] - 4;
                    m_dx = -m_dx;
                    if (m_mode == 2) m_last = pown[i];
                end
            end
        end
        win = 0;
        mouth = (ny >= 130 && ny < 350);
        if (!hit && nx < 24) begin
            if (m_mode >= 2 || (m_mode == 1 && !mouth)) begin nx = 34; m_dx = 1; end
            else win = 2;
        end else if (!hit && nx > 616) begin
            if (m_mode == 1 && !mouth) begin nx = 606; m_dx = -1; end
            else if (m_mode == 3) begin
                m_st = MS_SERVE; m_cnt = 0; m_x = 320; m_y = 240;
                return;
            end
            else if (m_mode == 2) win = (m_last == 2) ? 1 : 2;
            else win = 1;
        end
        if (win != 0) begin
            if (win == 1) m_p1++; else m_p2++;
            m_dx = (win == 1) ? 1 : -1;
            if (m_p1 == WIN_N || m_p2 == WIN_N) begin
                m_st = MS_OVER; m_x = 320; m_y = 240;
            end else begin
                m_st = MS_POINT; m_cnt = 0; m_x = nx; m_y = ny;
            end
        end else begin
            m_x = nx; m_y = ny;
        end
    endtask

    // ---------------- drive / compare ----------------
    task automatic cyc(input bit st, input bit tk, input bit [1:0] md,
                       input bit bs, input int py1, input int py2);
        start = st; frame_tick = tk; mode = md; bat_size = bs;
        p1_y = 11'(py1); p2_y = 11'(py2);
        model_step(st, tk, int'(md), bs, py1 & 2047, py2 & 2047);
        @(posedge clk); #1;
        start = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic cmp6(input string nm, input int ex, input int ey,
                        input int e1, input int e2, input bit ego, input bit epl);
        n_vec++;
        if (ball_x !== 11'(ex) || ball_y !== 11'(ey) || p1_score !== 6'(e1) ||
            p2_score !== 6'(e2) || game_over !== ego || playing !== epl) begin
            n_bad++;
            $display("FAIL %s: got (%0d,%0d) p1=%0d p2=%0d go=%0b play=%0b, want (%0d,%0d) p1=%0d p2=%0d go=%0b play=%0b",
                     nm, ball_x, ball_y, p1_score, p2_score, game_over, playing,
                     ex, ey, e1, e2, ego, epl);
        end
    endtask

    task automatic check_model(input string nm);
        cmp6(nm, m_x, m_y, m_p1, m_p2, m_st == MS_OVER, m_st == MS_PLAY);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; frame_tick = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string name;
        int n;
        bit st, tk, bs;
        int py1, py2;
        int ex, ey, e1, e2;
        bit ego, epl;
    } vec_t;
    vec_t tv[$];

    task automatic add(input string nm, input int n, input bit st, input bit tk,
                       input bit bs, input int py1, input int py2, input int ex,
                       input int ey, input int e1, input int e2, input bit ego,
                       input bit epl);
        vec_t v;
        v.name = nm; v.n = n; v.st = st; v.tk = tk; v.bs = bs;
        v.py1 = py1; v.py2 = py2; v.ex = ex; v.ey = ey; v.e1 = e1; v.e2 = e2;
        v.ego = ego; v.epl = epl;
        tv.push_back(v);
    endtask

    initial begin
        // Tennis from reset, paddles parked off-field unless stated.
        add("reset",        1,  0, 0, 0, 1000, 1000, 320, 240, 0, 0, 0, 0);
        add("start",        1,  1, 0, 0, 1000, 1000, 320, 240, 0, 0, 0, 0);
        add("serve_59",     59, 0, 1, 0, 1000, 1000, 320, 240, 0, 0, 0, 0);
        add("serve_60",     1,  0, 1, 0, 1000, 1000, 320, 240, 0, 0, 0, 1);
        add("first_move",   1,  0, 1, 0, 1000, 1000, 322, 242, 0, 0, 0, 1);
        add("bottom_wall",  132,0, 1, 0, 1000, 1000, 586, 388, 0, 0, 0, 1);
        add("p2_return",    1,  0, 1, 0, 1000, 388,  586, 386, 0, 0, 0, 1);
        add("after_p2",     1,  0, 1, 0, 1000, 1000, 584, 384, 0, 0, 0, 1);
        add("to_left_edge", 280,0, 1, 0, 1000, 1000, 24,  242, 0, 0, 0, 1);
        add("p2_point",     1,  0, 1, 0, 1000, 1000, 22,  244, 0, 1, 0, 0);
        add("point_59",     59, 0, 1, 0, 1000, 1000, 22,  244, 0, 1, 0, 0);
        add("point_60",     1,  0, 1, 0, 1000, 1000, 320, 240, 0, 1, 0, 1);
        add("serve_to_p1",  1,  0, 1, 0, 1000, 1000, 318, 242, 0, 1, 0, 1);
        add("to_p1",        134,0, 1, 0, 1000, 1000, 50,  384, 0, 1, 0, 1);
        add("p1_bigbat",    1,  0, 1, 1, 348,  1000, 54,  382, 0, 1, 0, 1);
        add("after_p1",     1,  0, 1, 0, 1000, 1000, 56,  380, 0, 1, 0, 1);

        rst = 1'b1; start = 1'b0; frame_tick = 1'b0; mode = 2'b00;
        bat_size = 1'b0; p1_y = '0; p2_y = '0;
        model_reset();
        #12;
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (tv[r]) begin
            for (int k = 0; k < tv[r].n; k++)
                cyc(tv[r].st, tv[r].tk, 2'b00, tv[r].bs, tv[r].py1, tv[r].py2);
            cmp6(tv[r].name, tv[r].ex, tv[r].ey, tv[r].e1, tv[r].e2,
                 tv[r].ego, tv[r].epl);
        end

        // Randomized play in each mode, paddles hovering near the ball.
        // mode is scrambled every cycle: only the value at start counts.
        for (int m = 0; m < 4; m++) begin
            do_reset();
            cyc(1'b1, 1'b0, 2'(m), 1'b0, 1000, 1000);
            check_model("mode_start");
            for (int i = 0; i < 1500; i++) begin
                int a, b;
                a = m_y + int'($urandom_range(0, 80)) - 40;
                b = m_y + int'($urandom_range(0, 80)) - 40;
                if (a < 0) a = 0;
                if (b < 0) b = 0;
                if ($urandom_range(0, 3) == 0) a = 2000;
                cyc(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, b);
                check_model("mode_run");
            end
        end

        // Mid-game asynchronous reset.
        do_reset();
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 2000, 2000);
        for (int i = 0; i < 3000 && m_p1 < 3; i++) begin
            cyc(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 2000, 2000);
            check_model("pre_async");
        end
        #2 rst = 1'b1;
        #1 cmp6("async_rst", 320, 240, 0, 0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // Full tennis game won by P1 (ball always re-served toward P2).
        cyc(1'b1, 1'b0, 2'b00, 1'b0, 2000, 2000);
        check_model("go_start");
        for (int i = 0; i < 6000 && m_st != MS_OVER; i++) begin
            cyc(($urandom_range(0, 9) == 0), 1'b1, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 2000, 2000);
            check_model("go_run");
        end
        if (m_st != MS_OVER) begin
            n_vec++; n_bad++;
            $display("FAIL go_bound: game not over within budget, p1=%0d p2=%0d want p1=%0d",
                     p1_score, p2_score, WIN_N);
        end
        cmp6("game_over", 320, 240, WIN_N, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, 2000, 2000);
        cmp6("over_hold", 320, 240, WIN_N, 0, 1'b1, 1'b0);

        // Restart with a coincident tick: the tick is not counted.
        cyc(1'b1, 1'b1, 2'b00, 1'b0, 2000, 2000);
        cmp6("restart", 320, 240, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < SERVE_N - 1; i++) cyc(1'b0, 1'b1, 2'b00, 1'b0, 2000, 2000);
        cmp6("restart_59", 320, 240, 0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 1'b0, 2000, 2000);
        cmp6("restart_60", 320, 240, 0, 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ball_controller.md
# ball_controller

Game sequencer for the ball-and-paddle display path. Once per video frame it advances the ball, resolves wall, paddle and goal collisions for the latched game mode, and keeps both scores. It runs the serve / play / point / game-over sequence. Its ball_x, ball_y, p1_score and p2_score outputs feed the video encoder directly.

## Interface
- WIN_SCORE, 11: points that end a game; must be ≤ 63.
- SERVE_FRAMES, 60: frame ticks of pause before each serve.
- SPEED, 2: pixels moved per frame on each axis; must be 1..4.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse, once per frame, at vertical-blank start
- start  in  1  one-cycle pulse, starts a new game
- mode  in  2  00 tennis, 01 football, 10 squash, 11 practice
- bat_size  in  1  paddle half-height: 1 = 35, 0 = 25
- p1_y, p2_y  in  11  paddle centre rows
- ball_x, ball_y  out  11  ball centre; the ball box is [c-4, c+4)
- p1_score, p2_score  out  6  scores
- game_over  out  1  high while in OVER
- playing  out  1  high while in PLAY

## Operation
- States are IDLE, SERVE, PLAY, POINT and OVER.
  - Reset: IDLE, ball at (320,240), dx=+1, dy=+1, scores 0, game_over 0, playing 0, last_hitter = P1, frame counter 0.
- IDLE or OVER, start pulse:
  - Clear both scores; mode is latched into mode_q.
  - Ball goes to (320,240); frame counter cleared; next state SERVE.
  - start in SERVE, PLAY or POINT is ignored.
  - mode changes outside IDLE/OVER have no effect.
- SERVE: count frame ticks; on the SERVE_FRAMES-th tick go to PLAY. The ball does not move.
- PLAY, on each frame_tick:
  - Compute nx = x + dx·SPEED and ny = y + dy·SPEED.
  - Position arithmetic is 12-bit signed; positions are stored back as 11-bit.
- Wall (y axis):
  - ny < 34: ny = 34, dy = +1.
  - ny > 446: ny = 446, dy = −1.
- Paddle columns (left edge L, width 10) and the direction of ball travel each one reflects:
  - Tennis: P1 at 40 reflects dx −1. P2 at 590 reflects dx +1.
  - Football: P1 at 40 and P1F at 480 reflect dx −1. P2 at 590 and P2F at 150 reflect dx +1.
  - Squash and practice: P1F at 480 and P2S at 500 both reflect dx +1.
- Paddle hit, all conditions required:
  - The box [nx−4, nx+4) overlaps [L, L+10).
  - ny lies in [py−size, py+size), size taken from the current bat_size.
  - dx matches the paddle's reflect direction.
- Paddle hit response:
  - dx flips; nx = L+14 for a reflected dx −1, nx = L−4 for a reflected dx +1.
  - In squash, last_hitter is updated.
  - Paddles are checked in the order listed above; the first hit wins, and the goal check is skipped that frame.
- Left edge (nx < 24):
  - Squash and practice: wall; nx = 34, dx = +1.
  - Football with ny outside [130, 350): reflect, nx = 34, dx = +1.
  - Otherwise: point to P2.
- Right edge (nx > 616):
  - Football with ny outside [130, 350): reflect, nx = 606, dx = −1.
  - Tennis and football otherwise: point to P1.
  - Squash: point to the player who is not last_hitter.
  - Practice: no point; go straight back to SERVE.
- Point:
  - Increment the winner's score and freeze the ball at nx, ny.
  - If the new score equals WIN_SCORE, go to OVER.
  - Otherwise go to POINT.
- POINT: after SERVE_FRAMES ticks, ball to (320,240), dx toward the player who lost the point, dy unchanged; go to PLAY.
- OVER: ball at (320,240), game_over=1; wait for start.

## Timing
- All outputs are registered. A frame_tick at cycle n shows its ball and score update at cycle n+1.
- The start pulse takes effect at n+1: state SERVE, scores 0.
- start and frame_tick in the same cycle in IDLE/OVER: start wins, and that tick is not counted.
- Each tick produces one update; ticks arriving closer than 2 cycles apart are still each processed.
- playing is high exactly in PLAY; game_over is high exactly in OVER.
- rst asserted mid-game returns every output to its reset value asynchronously.

## Test plan
- Reset, then start, then 60 ticks: playing rises after the 60th tick. One more tick moves the ball to (322,242).
- Tennis, ball (50,240), dx −1, p1_y=240: the next tick gives ball_x=54, dx +1, and no score.
- Tennis, p1_y=100, ball moving left past x=24: p2_score becomes 1, POINT lasts 60 ticks, and the ball re-serves from (320,240) toward P1.
- Football, ball at y=60 reaching x<24: reflects with ball_x=34. At y=240 it scores for P2.
- Squash, last_hitter P2S, ball exits right: p1_score increments. In practice mode no score changes.
- P1 at 10 scores a point: p1_score=11, game_over=1. Then start: scores 0, SERVE. A mode change mid-PLAY leaves behaviour unchanged.
